serial_addsub_acc: RTL and testbench

Parametrised successor to the lab adder datapath. It serially loads operand A one bit per debounced button press and adds or subtracts a parallel operand B. It supports a signed/unsigned overflow mode and an accumulate mode that folds each result back in as the next operand. It sits between the debouncer and the display driver; `result` feeds the display and `ov`/`ov_sticky` drive LEDs.

---
 rtl/adder_pkg.sv | 30 +++
 rtl/rise_detect.sv | 35 +++
 rtl/serial_addsub_acc.sv | 177 +++++++++++++++++
 tb/tb_serial_addsub_acc.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_pkg
//  Description : Shared types and constants for the serial add/sub
//                accumulator: the load-state encoding, the default operand
//                width and the encodings of the sub / signed_mode selects.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

  // Default operand/result width
  localparam int DEFAULT_WIDTH = 4;

  // Operation select (sub input)
  localparam logic SUB_ADD = 1'b0;
  localparam logic SUB_SUB = 1'b1;

  // Overflow rule select (signed_mode input)
  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  // Serial-load state of operand A
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_FULL    = 2'd2
  } load_state_t;

endpackage : adder_pkg
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// ============================================================================
//  Module      : rise_detect
//  Description : Rising-edge detector for a debounced level. The previous
//                level is registered; pulse is high while level=1 and the
//                previous level was 0, so the consumer sees the event at the
//                same clock edge at which the level is first sampled high.
//                A held level produces exactly one pulse.
//  Ports       : clk   - system clock (rising edge)
//                rst_n - synchronous active-low reset (prev cleared to 0)
//                level - debounced input level
//                pulse - one-cycle rise indication
//  Revision    : 1.0 - initial release
// ============================================================================
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= level;
    end
  end

  assign pulse = level & ~r_prev;

endmodule : rise_detect
`default_nettype wire

// File: rtl/serial_addsub_acc.sv
`default_nettype none
// ============================================================================
//  Module      : serial_addsub_acc
//  Description : Serially loaded add/subtract unit with unsigned / two's-
//                complement overflow rules and an accumulate mode that uses
//                the current result as the next X operand.
//  Ports       : clk         - system clock (rising edge)
//                rst_n       - synchronous active-low reset
//                shift, si   - shift strobe (level) and serial data bit
//                commit      - commit strobe (level), one operation per rise
//                clr         - synchronous clear, active high
//                b           - parallel operand B
//                sub         - 0: X+B, 1: X-B
//                signed_mode - 0: unsigned overflow, 1: signed overflow
//                acc_mode    - 0: X=A, 1: X=result
//                a_val       - current A register
//                a_full      - WIDTH bits loaded since last clear
//                result      - registered result
//                ov          - overflow of most recent operation
//                ov_sticky   - OR of ov since last clear
//                done        - one-cycle pulse after each commit
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub_acc
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift,
  input  logic             si,
  input  logic             commit,
  input  logic             clr,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             signed_mode,
  input  logic             acc_mode,
  output logic [WIDTH-1:0] a_val,
  output logic             a_full,
  output logic [WIDTH-1:0] result,
  output logic             ov,
  output logic             ov_sticky,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(WIDTH);

  // --------------------------------------------------------------------------
  // Strobe edge detection
  // --------------------------------------------------------------------------
  logic w_shift_ev;
  logic w_commit_ev;

  rise_detect u_shift_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .level (shift),
    .pulse (w_shift_ev)
  );

  rise_detect u_commit_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .level (commit),
    .pulse (w_commit_ev)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_a;
  logic [CNT_W-1:0] r_cnt;
  load_state_t      r_state;
  logic [WIDTH-1:0] r_result;
  logic             r_ov;
  logic             r_ov_sticky;
  logic             r_done;

  // --------------------------------------------------------------------------
  // Add/subtract and overflow
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_x;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_ov;
  logic             w_xs;
  logic             w_bs;
  logic             w_rs;

  always_comb begin
    w_x = acc_mode ? r_result : r_a;
    if (sub == SUB_SUB) begin
      w_sum = {1'b0, w_x} - {1'b0, b};
    end else begin
      w_sum = {1'b0, w_x} + {1'b0, b};
    end
    w_res = w_sum[WIDTH-1:0];
    w_xs  = w_x[WIDTH-1];
    w_bs  = b[WIDTH-1];
    w_rs  = w_res[WIDTH-1];

    if (signed_mode == MODE_SIGNED) begin
      if (sub == SUB_SUB) begin
        w_ov = (w_xs != w_bs) && (w_rs != w_xs);
      end else begin
        w_ov = (w_xs == w_bs) && (w_rs != w_xs);
      end
    end else begin
      // The extra MSB is the carry for an add and the borrow (X<B) for a
      // subtract, since the zero-extended difference wraps when X<B.
      w_ov = w_sum[WIDTH];
    end
  end

  // Saturating bit count and the load state it implies
  logic [CNT_W-1:0] w_cnt_next;
  load_state_t      w_state_next;

  always_comb begin
    w_cnt_next   = (r_cnt == C_CNT_FULL) ? r_cnt : r_cnt + 1'b1;
    w_state_next = (w_cnt_next == C_CNT_FULL) ? ST_FULL : ST_LOADING;
  end

  // --------------------------------------------------------------------------
  // Registers. Reset beats clear, clear beats events. A simultaneous commit
  // reads r_a before the shift below updates it, giving pre-shift A.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_cnt       <= '0;
      r_state     <= ST_EMPTY;
      r_result    <= '0;
      r_ov        <= 1'b0;
      r_ov_sticky <= 1'b0;
      r_done      <= 1'b0;
    end else if (clr) begin
      r_a         <= '0;
      r_cnt       <= '0;
      r_state     <= ST_EMPTY;
      r_result    <= '0;
      r_ov        <= 1'b0;
      r_ov_sticky <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_commit_ev;

      if (w_shift_ev) begin
        r_a   <= {r_a[WIDTH-2:0], si};
        r_cnt <= w_cnt_next;
        case (r_state)
          ST_EMPTY:   r_state <= w_state_next;
          ST_LOADING: r_state <= w_state_next;
          ST_FULL:    r_state <= ST_FULL;
          default:    r_state <= ST_EMPTY;
        endcase
      end

      if (w_commit_ev) begin
        r_result    <= w_res;
        r_ov        <= w_ov;
        r_ov_sticky <= r_ov_sticky | w_ov;
      end
    end
  end

  assign a_val     = r_a;
  assign a_full    = (r_state == ST_FULL);
  assign result    = r_result;
  assign ov        = r_ov;
  assign ov_sticky = r_ov_sticky;
  assign done      = r_done;

endmodule : serial_addsub_acc
`default_nettype wire

// File: tb/tb_serial_addsub_acc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_addsub_acc
//  Description : Directed self-checking bench for serial_addsub_acc, WIDTH=4.
//                Inputs change on the falling edge; outputs are sampled on
//                the falling edge after the rising edge that updates them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_addsub_acc;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             shift;
  logic             si;
  logic             commit;
  logic             clr;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             signed_mode;
  logic             acc_mode;
  logic [WIDTH-1:0] a_val;
  logic             a_full;
  logic [WIDTH-1:0] result;
  logic             ov;
  logic             ov_sticky;
  logic             done;

  int n_tests = 0;
  int n_fail  = 0;

  serial_addsub_acc #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .shift       (shift),
    .si          (si),
    .commit      (commit),
    .clr         (clr),
    .b           (b),
    .sub         (sub),
    .signed_mode (signed_mode),
    .acc_mode    (acc_mode),
    .a_val       (a_val),
    .a_full      (a_full),
    .result      (result),
    .ov          (ov),
    .ov_sticky   (ov_sticky),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic shift_bit(input logic v);
    @(negedge clk);
    si    = v;
    shift = 1'b1;
    @(negedge clk);
    shift = 1'b0;
  endtask

  task automatic load_a(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) shift_bit(v[i]);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Raise commit for one cycle; on return the done cycle is being sampled.
  task automatic do_commit(input logic [3:0] bv, input logic s, input logic sg, input logic acc);
    @(negedge clk);
    b           = bv;
    sub         = s;
    signed_mode = sg;
    acc_mode    = acc;
    commit      = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  int done_cnt;
  int res_changes;
  logic [3:0] prev_res;
  logic [3:0] acc_exp [6] = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd2};

  initial begin
    rst_n = 1'b0; shift = 1'b0; si = 1'b0; commit = 1'b0; clr = 1'b0;
    b = '0; sub = 1'b0; signed_mode = 1'b0; acc_mode = 1'b0;

    // Reset with strobes toggling
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      shift = ~shift; commit = ~commit; si = 1'b1;
    end
    @(negedge clk);
    check("rst_a_val", 32'(a_val), 32'h0);
    check("rst_a_full", 32'(a_full), 32'h0);
    check("rst_result", 32'(result), 32'h0);
    check("rst_ov", 32'(ov), 32'h0);
    check("rst_sticky", 32'(ov_sticky), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    shift = 1'b0; commit = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // First shift after reset loads exactly one bit
    shift_bit(1'b1);
    check("first_shift_a", 32'(a_val), 32'h1);
    check("first_shift_full", 32'(a_full), 32'h0);
    shift_bit(1'b0); shift_bit(1'b1);
    check("three_bits_full", 32'(a_full), 32'h0);
    shift_bit(1'b1);
    check("load_B_a", 32'(a_val), 32'hB);
    check("load_B_full", 32'(a_full), 32'h1);

    // Unsigned add with carry
    do_commit(4'd6, 1'b0, 1'b0, 1'b0);
    check("uadd_done", 32'(done), 32'h1);
    check("uadd_result", 32'(result), 32'h1);
    check("uadd_ov", 32'(ov), 32'h1);
    @(negedge clk);
    check("uadd_done_drop", 32'(done), 32'h0);

    // Shift past full discards the oldest bit
    shift_bit(1'b0);
    check("fifth_shift_a", 32'(a_val), 32'h6);
    check("fifth_shift_full", 32'(a_full), 32'h1);

    // Signed: -5 + 6 = 1, no overflow
    do_clear();
    check("clr_sticky", 32'(ov_sticky), 32'h0);
    load_a(4'hB);
    do_commit(4'd6, 1'b0, 1'b1, 1'b0);
    check("sadd_neg_result", 32'(result), 32'h1);
    check("sadd_neg_ov", 32'(ov), 32'h0);
    check("sadd_neg_sticky", 32'(ov_sticky), 32'h0);

    // Signed: 7 + 1 overflows
    do_clear();
    load_a(4'h7);
    do_commit(4'd1, 1'b0, 1'b1, 1'b0);
    check("sadd_ov_result", 32'(result), 32'h8);
    check("sadd_ov_ov", 32'(ov), 32'h1);

    // Signed: 7 - 1 = 6, no overflow (different X/B sign rule not met)
    do_commit(4'd1, 1'b1, 1'b1, 1'b0);
    check("ssub_result", 32'(result), 32'h6);
    check("ssub_ov", 32'(ov), 32'h0);
    // Signed: 7 - (-8) overflows
    do_commit(4'h8, 1'b1, 1'b1, 1'b0);
    check("ssub_ov_result", 32'(result), 32'hF);
    check("ssub_ov_ov", 32'(ov), 32'h1);

    // Unsigned: 3 - 5 borrows
    do_clear();
    load_a(4'h3);
    do_commit(4'd5, 1'b1, 1'b0, 1'b0);
    check("usub_result", 32'(result), 32'hE);
    check("usub_ov", 32'(ov), 32'h1);
    // Unsigned: 3 - 2, no borrow
    do_commit(4'd2, 1'b1, 1'b0, 1'b0);
    check("usub_nb_result", 32'(result), 32'h1);
    check("usub_nb_ov", 32'(ov), 32'h0);
    check("usub_nb_sticky", 32'(ov_sticky), 32'h1);

    // Accumulate B=3 six times
    do_clear();
    for (int i = 0; i < 6; i++) begin
      do_commit(4'd3, 1'b0, 1'b0, 1'b1);
      check($sformatf("acc_result_%0d", i), 32'(result), 32'(acc_exp[i]));
      check($sformatf("acc_ov_%0d", i), 32'(ov), (i == 5) ? 32'h1 : 32'h0);
    end
    do_commit(4'd3, 1'b0, 1'b0, 1'b1);
    check("acc_after_result", 32'(result), 32'h5);
    check("acc_after_ov", 32'(ov), 32'h0);
    check("acc_after_sticky", 32'(ov_sticky), 32'h1);
    do_clear();
    check("acc_clr_sticky", 32'(ov_sticky), 32'h0);
    check("acc_clr_result", 32'(result), 32'h0);

    // Simultaneous shift and commit: commit uses pre-shift A
    load_a(4'h2);
    @(negedge clk);
    b = 4'd1; sub = 1'b0; signed_mode = 1'b0; acc_mode = 1'b0;
    si = 1'b1; shift = 1'b1; commit = 1'b1;
    @(negedge clk);
    shift = 1'b0; commit = 1'b0;
    check("simul_result", 32'(result), 32'h3);
    check("simul_a_val", 32'(a_val), 32'h5);
    check("simul_done", 32'(done), 32'h1);

    // Clear on the same cycle as commit wins
    @(negedge clk);
    clr = 1'b1; commit = 1'b1;
    @(negedge clk);
    clr = 1'b0; commit = 1'b0;
    check("clr_commit_result", 32'(result), 32'h0);
    check("clr_commit_done", 32'(done), 32'h0);
    check("clr_commit_a_val", 32'(a_val), 32'h0);

    // Held commit: exactly one operation
    load_a(4'h5);
    @(negedge clk);
    b = 4'd4; sub = 1'b0; acc_mode = 1'b0; signed_mode = 1'b0;
    commit = 1'b1;
    done_cnt = 0;
    res_changes = 0;
    prev_res = result;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (result !== prev_res) res_changes++;
      prev_res = result;
    end
    commit = 1'b0;
    check("held_done_count", 32'(done_cnt), 32'd1);
    check("held_result_updates", 32'(res_changes), 32'd1);
    check("held_result", 32'(result), 32'h9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_serial_addsub_acc
`default_nettype wire
